fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_ifid_reg.sv | 39 +++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode-stage control unit:
// fetch FSM encoding, NOP word, opcode field position and default reset PC.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetchState_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam int          OPCODE_MSB       = 31;
   localparam int          OPCODE_LSB       = 26;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats a valid-only bubble,
// and no request leaves everything as it was.
module ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic              bubble,
   input  logic              loadValid,
   input  logic [31:0]       loadInstr,
   input  logic [ADDR_W-1:0] loadPc4,
   output logic              valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc4
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc4   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= loadValid;
         instr <= loadInstr;
         pc4   <= loadPc4;
      end else if (bubble) begin
         // Bubble only marks the slot empty; the stale word is never consumed.
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory handshake, one-entry skid
// buffer for words returned during a stall, and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              ifid_valid,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc4,
   output logic [5:0]        ifid_opcode
);

   fetchState_t       stateReg;
   fetchState_t       stateNext;
   logic              reqEnReg;
   logic [ADDR_W-1:0] pcReg;
   logic [ADDR_W-1:0] pcPlus4;
   logic [ADDR_W-1:0] drainAddrReg;
   logic [31:0]       skidReg;
   logic              skidValidReg;

   logic              ifidLoad;
   logic              ifidFlush;
   logic              ifidBubble;
   logic              loadValid;
   logic [31:0]       loadInstr;
   logic              pcAdvance;
   logic              skidCapture;
   logic              drainEnter;

   assign pcPlus4 = pcReg + ADDR_W'(4);

   // State register; reqEnReg keeps the request low until the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg <= FETCH;
         reqEnReg <= 1'b0;
      end else begin
         stateReg <= stateNext;
         reqEnReg <= 1'b1;
      end
   end

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         FETCH: begin
            if (redirect)
               stateNext = (reqEnReg && !imem_ready) ? DRAIN : FETCH;
            else if (reqEnReg && imem_ready && stall)
               stateNext = HOLD;
         end
         HOLD: begin
            if (redirect || !stall)
               stateNext = FETCH;
         end
         DRAIN: begin
            // A redirect here only retargets the PC; the old request must finish.
            if (imem_ready)
               stateNext = FETCH;
         end
         default: stateNext = FETCH;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      imem_addr   = pcReg;
      ifidLoad    = 1'b0;
      ifidFlush   = redirect;
      ifidBubble  = 1'b0;
      loadValid   = 1'b1;
      loadInstr   = imem_rdata;
      pcAdvance   = 1'b0;
      skidCapture = 1'b0;
      unique case (stateReg)
         FETCH: begin
            imem_req = reqEnReg;
            if (reqEnReg && !redirect) begin
               if (imem_ready && !stall) begin
                  ifidLoad  = 1'b1;
                  pcAdvance = 1'b1;
               end else if (imem_ready) begin
                  skidCapture = 1'b1;
               end else if (!stall) begin
                  ifidBubble = 1'b1;
               end
            end
         end
         HOLD: begin
            if (!redirect && !stall) begin
               ifidLoad  = 1'b1;
               loadInstr = skidReg;
               loadValid = skidValidReg;
               pcAdvance = 1'b1;
            end
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drainAddrReg;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   assign drainEnter = (stateReg == FETCH) && (stateNext == DRAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcReg        <= RESET_PC;
         drainAddrReg <= '0;
         skidReg      <= NOP_INSTR;
         skidValidReg <= 1'b0;
      end else begin
         if (redirect)
            pcReg <= redirect_pc;
         else if (pcAdvance)
            pcReg <= pcPlus4;

         if (drainEnter)
            drainAddrReg <= pcReg;

         if (redirect) begin
            skidValidReg <= 1'b0;
         end else if (skidCapture) begin
            skidReg      <= imem_rdata;
            skidValidReg <= 1'b1;
         end else if (ifidLoad && stateReg == HOLD) begin
            skidValidReg <= 1'b0;
         end
      end
   end

   ifid_reg #(
      .ADDR_W (ADDR_W)
   ) u_ifid (
      .clk       (clk),
      .rst       (rst),
      .load      (ifidLoad),
      .flush     (ifidFlush),
      .bubble    (ifidBubble),
      .loadValid (loadValid),
      .loadInstr (loadInstr),
      .loadPc4   (pcPlus4),
      .valid     (ifid_valid),
      .instr     (ifid_instr),
      .pc4       (ifid_pc4)
   );

   assign ifid_opcode = opcodeOf(ifid_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: address-derived instruction memory, one
// line per checked step, immediate assertions at every comparison point.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic [5:0]  ifid_opcode;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[7:2] ^ 6'h23, a[25:0]};
   endfunction

   assign imem_rdata = memWord(imem_addr);

   fetch_stage #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ifid_valid  (ifid_valid),
      .ifid_instr  (ifid_instr),
      .ifid_pc4    (ifid_pc4),
      .ifid_opcode (ifid_opcode)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic showStep(input string step);
      $display("[%0t] %s req=%0b addr=%h valid=%0b instr=%h pc4=%h op=%h",
               $time, step, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4, ifid_opcode);
   endtask

   task automatic chkIfid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] p4);
      chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
      chk({tag, ".instr"}, ifid_instr, ins);
      chk({tag, ".pc4"}, ifid_pc4, p4);
   endtask

   initial begin
      rst         = 1'b1;
      imem_ready  = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      // Reset state
      #2;
      showStep("reset");
      chk("rst.req", 32'(imem_req), 32'h0);
      chkIfid("rst", 1'b0, 32'h0, 32'h0);
      chk("rst.opcode", 32'(ifid_opcode), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      chk("rel.req", 32'(imem_req), 32'h0);

      // 1: streaming fetch with zero-wait memory
      tick();
      showStep("t1.first");
      chk("t1.req", 32'(imem_req), 32'h1);
      chk("t1.addr0", imem_addr, 32'h0);
      chk("t1.valid0", 32'(ifid_valid), 32'h0);
      for (int k = 1; k <= 2; k++) begin
         tick();
         showStep("t1.stream");
         chkIfid("t1", 1'b1, memWord(32'(4 * (k - 1))), 32'(4 * k));
         chk("t1.addr", imem_addr, 32'(4 * k));
         chk("t1.opcode", 32'(ifid_opcode), 32'(memWord(32'(4 * (k - 1))) >> 26));
      end

      // 2: memory wait states at 0x8
      imem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         showStep("t2.wait");
         chk("t2.addr", imem_addr, 32'h8);
         chk("t2.bubble", 32'(ifid_valid), 32'h0);
      end
      imem_ready = 1'b1;
      tick();
      showStep("t2.done");
      chkIfid("t2", 1'b1, memWord(32'h8), 32'hC);
      chk("t2.next", imem_addr, 32'hC);

      // 3: stall with ready high, word at 0xC goes to the skid buffer
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         showStep("t3.stall");
         chkIfid("t3.frozen", 1'b1, memWord(32'h8), 32'hC);
         chk("t3.hold.req", 32'(imem_req), 32'h0);
      end
      stall = 1'b0;
      tick();
      showStep("t3.release");
      chkIfid("t3.skid", 1'b1, memWord(32'hC), 32'h10);
      chk("t3.req", 32'(imem_req), 32'h1);
      chk("t3.addr", imem_addr, 32'h10);
      tick();
      showStep("t3.next");
      chkIfid("t3.after", 1'b1, memWord(32'h10), 32'h14);

      // 4: redirect to 0x40 while stalled
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      showStep("t4.redirect");
      chk("t4.valid", 32'(ifid_valid), 32'h0);
      chk("t4.instr", ifid_instr, 32'h0);
      chk("t4.opcode", 32'(ifid_opcode), 32'h0);
      chk("t4.addr", imem_addr, 32'h40);
      chk("t4.req", 32'(imem_req), 32'h1);
      stall    = 1'b0;
      redirect = 1'b0;
      tick();
      showStep("t4.target");
      chkIfid("t4.load", 1'b1, memWord(32'h40), 32'h44);

      // 5: redirect to 0x100 while the request at 0x20 is outstanding
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      tick();
      redirect   = 1'b0;
      imem_ready = 1'b0;
      tick();
      showStep("t5.pending");
      chk("t5.addr20", imem_addr, 32'h20);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      showStep("t5.drain");
      chk("t5.drain.addr", imem_addr, 32'h20);
      chk("t5.drain.req", 32'(imem_req), 32'h1);
      tick();
      chk("t5.drain.hold", imem_addr, 32'h20);
      imem_ready = 1'b1;
      tick();
      showStep("t5.discard");
      chk("t5.discard", 32'(ifid_valid), 32'h0);
      chk("t5.newaddr", imem_addr, 32'h100);
      tick();
      showStep("t5.target");
      chkIfid("t5.load", 1'b1, memWord(32'h100), 32'h104);

      // 6: PC wrap, then reset during DRAIN and during a valid IF/ID
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("t6.top", imem_addr, 32'hFFFF_FFFC);
      tick();
      showStep("t6.wrap");
      chkIfid("t6.wrap", 1'b1, memWord(32'hFFFF_FFFC), 32'h0);
      chk("t6.addr0", imem_addr, 32'h0);
      imem_ready  = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      chk("t6.drain.req", 32'(imem_req), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      showStep("t6.rst.drain");
      chk("t6.rst.req", 32'(imem_req), 32'h0);
      chk("t6.rst.valid", 32'(ifid_valid), 32'h0);
      tick();
      rst        = 1'b0;
      imem_ready = 1'b1;
      tick();
      chk("t6.restart.addr", imem_addr, 32'h0);
      tick();
      chkIfid("t6.restart", 1'b1, memWord(32'h0), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      showStep("t6.rst.valid");
      chkIfid("t6.rst.async", 1'b0, 32'h0, 32'h0);
      chk("t6.rst.req2", 32'(imem_req), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
